// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM counter-mode stream: block width, mode and
// FSM encodings, and the AES round primitives used by aes_core.
package gcm_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    MODE_CTR    = 2'd0,
    MODE_HASH   = 2'd1,
    MODE_PRETAG = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_INIT = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_BLK_WAIT = 3'd3,
    ST_CIPHER   = 3'd4,
    ST_OUT      = 3'd5
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Next four schedule words from the previous four and the newest word;
  // rot selects the RotWord+Rcon step (AES-256 alternates it with plain SubWord).
  function automatic logic [127:0] expand4(input logic [127:0] prev, input logic [31:0] last_w,
                                           input logic rot, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon, 24'h0}) : sub_word(last_w);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

endpackage

// File: rtl/aes_core.sv
// Iterative AES-128/256 encryptor, one round per clock; the key schedule is
// regenerated alongside the rounds so only the cipher key is stored.
module aes_core
  import gcm_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iInit,
  input  logic             iNext,
  input  logic [255:0]     iKey,
  input  logic             iKeylen,
  input  logic [BLK_W-1:0] iBlock,
  output logic             oReady,
  output logic [BLK_W-1:0] oResult,
  output logic             oResult_valid
);

  logic [255:0]     key_r;
  logic             klen_r;
  logic             init_pend;
  logic             busy;
  logic [3:0]       round;
  logic [BLK_W-1:0] st, ka, kb;
  logic [7:0]       rcon;
  logic             rot;
  logic [3:0]       last_round;
  logic [BLK_W-1:0] st_next;

  assign last_round = klen_r ? 4'd14 : 4'd10;
  assign st_next    = aes_round(st, ka, round == last_round);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      key_r         <= '0;
      klen_r        <= 1'b0;
      init_pend     <= 1'b0;
      busy          <= 1'b0;
      round         <= '0;
      st            <= '0;
      ka            <= '0;
      kb            <= '0;
      rcon          <= '0;
      rot           <= 1'b0;
      oReady        <= 1'b0;
      oResult       <= '0;
      oResult_valid <= 1'b0;
    end else begin
      oResult_valid <= 1'b0;
      if (iInit) begin
        key_r     <= iKey;
        klen_r    <= iKeylen;
        oReady    <= 1'b0;
        init_pend <= 1'b1;
        busy      <= 1'b0;
      end else if (init_pend) begin
        init_pend <= 1'b0;
        oReady    <= 1'b1;
      end else if (iNext && oReady) begin
        oReady <= 1'b0;
        busy   <= 1'b1;
        round  <= 4'd1;
        st     <= iBlock ^ key_r[255:128];
        rcon   <= 8'h02;
        rot    <= 1'b0;
        if (klen_r) begin
          ka <= key_r[127:0];
          kb <= expand4(key_r[255:128], key_r[31:0], 1'b1, 8'h01);
        end else begin
          ka <= expand4(key_r[255:128], key_r[159:128], 1'b1, 8'h01);
          kb <= '0;
        end
      end else if (busy) begin
        st    <= st_next;
        round <= round + 4'd1;
        if (klen_r) begin
          ka  <= kb;
          kb  <= expand4(ka, kb[31:0], rot, rcon);
          rot <= ~rot;
          if (rot) rcon <= xtime(rcon);
        end else begin
          ka   <= expand4(ka, ka[31:0], 1'b1, rcon);
          rcon <= xtime(rcon);
        end
        if (round == last_round) begin
          busy          <= 1'b0;
          oReady        <= 1'b1;
          oResult       <= st_next;
          oResult_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gctr_stream.sv
// GCM counter-mode block stream: encrypts/decrypts blocks with IV||counter
// keystream, and also produces the hash key H and the pre-tag E(K,Y0).
module gctr_stream
  import gcm_pkg::*;
#(
  parameter int                 CTR_W     = 32,
  parameter int                 IV_W      = 128 - CTR_W,
  parameter logic [CTR_W-1:0]   CTR_START = CTR_W'(2)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [1:0]       iMode,
  input  logic             iKeyReuse,
  input  logic [IV_W-1:0]  iIV,
  input  logic [255:0]     iKey,
  input  logic             iKeylen,
  input  logic [BLK_W-1:0] iBlock,
  input  logic [4:0]       iBlock_bytes,
  input  logic             iLast,
  input  logic             iBlock_valid,
  output logic             oBlock_ready,
  output logic [BLK_W-1:0] oResult,
  output logic             oResult_valid,
  input  logic             iResult_ready,
  output logic             oResult_last,
  output logic             oBusy
);

  state_e           state;
  mode_e            mode_r;
  logic [IV_W-1:0]  iv_r;
  logic [CTR_W-1:0] ctr;
  logic [255:0]     key_r;
  logic             keylen_r;
  logic             key_valid;
  logic [BLK_W-1:0] blk_r;
  logic [4:0]       bytes_r;
  logic             last_r;
  logic [BLK_W-1:0] aes_in;
  logic             aes_init, aes_next;
  logic             aes_ready, aes_valid;
  logic [BLK_W-1:0] aes_res;
  logic [BLK_W-1:0] byte_mask;
  logic [4:0]       bytes_n;
  logic             start_ctr;

  assign bytes_n   = (iBlock_bytes == 5'd0 || iBlock_bytes > 5'd16) ? 5'd16 : iBlock_bytes;
  assign start_ctr = !(iMode == 2'd1 || iMode == 2'd2);

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 16; i++)
      byte_mask[BLK_W-1-8*i -: 8] = (5'(i) < bytes_r) ? 8'hFF : 8'h00;
  end

  aes_core u_aes (
    .iClk         (iClk),
    .iRst         (iRst),
    .iInit        (aes_init),
    .iNext        (aes_next),
    .iKey         (key_r),
    .iKeylen      (keylen_r),
    .iBlock       (aes_in),
    .oReady       (aes_ready),
    .oResult      (aes_res),
    .oResult_valid(aes_valid)
  );

  // Both streams use valid/ready: a beat moves on the rising edge where valid
  // and ready are both high; the sender holds data stable while valid waits.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state         <= ST_IDLE;
      mode_r        <= MODE_CTR;
      iv_r          <= '0;
      ctr           <= CTR_START;
      key_r         <= '0;
      keylen_r      <= 1'b0;
      key_valid     <= 1'b0;
      blk_r         <= '0;
      bytes_r       <= '0;
      last_r        <= 1'b0;
      aes_in        <= '0;
      aes_init      <= 1'b0;
      aes_next      <= 1'b0;
      oBlock_ready  <= 1'b0;
      oResult       <= '0;
      oResult_valid <= 1'b0;
      oResult_last  <= 1'b0;
      oBusy         <= 1'b0;
    end else begin
      aes_init <= 1'b0;
      aes_next <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            iv_r   <= iIV;
            mode_r <= start_ctr ? MODE_CTR : mode_e'(iMode);
            ctr    <= CTR_START;
            oBusy  <= 1'b1;
            if (iKeyReuse && key_valid) begin
              state        <= ST_BLK_WAIT;
              oBlock_ready <= start_ctr;
            end else begin
              key_r    <= iKey;
              keylen_r <= iKeylen;
              aes_init <= 1'b1;
              state    <= ST_KEY_INIT;
            end
          end
        end
        ST_KEY_INIT: state <= ST_KEY_WAIT;
        ST_KEY_WAIT: begin
          if (aes_ready) begin
            key_valid    <= 1'b1;
            oBlock_ready <= (mode_r == MODE_CTR);
            state        <= ST_BLK_WAIT;
          end
        end
        ST_BLK_WAIT: begin
          if (mode_r != MODE_CTR) begin
            aes_in   <= (mode_r == MODE_HASH) ? '0 : {iv_r, CTR_W'(1)};
            last_r   <= 1'b1;
            aes_next <= 1'b1;
            state    <= ST_CIPHER;
          end else if (iBlock_valid) begin
            blk_r        <= iBlock;
            bytes_r      <= bytes_n;
            last_r       <= iLast;
            aes_in       <= {iv_r, ctr};
            ctr          <= ctr + CTR_W'(1);
            oBlock_ready <= 1'b0;
            aes_next     <= 1'b1;
            state        <= ST_CIPHER;
          end
        end
        ST_CIPHER: begin
          if (aes_valid) begin
            oResult       <= (mode_r == MODE_CTR) ? ((aes_res ^ blk_r) & byte_mask) : aes_res;
            oResult_last  <= last_r;
            oResult_valid <= 1'b1;
            state         <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (iResult_ready) begin
            oResult_valid <= 1'b0;
            if (oResult_last) begin
              oBusy <= 1'b0;
              state <= ST_IDLE;
            end else begin
              oBlock_ready <= 1'b1;
              state        <= ST_BLK_WAIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream using published GCM/AES vectors; a second
// instance starts its counter at all-ones to exercise the counter wrap.
module tb_gctr_stream;
  import gcm_pkg::*;

  localparam logic [127:0] H0    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Y0_0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C0    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] K3    = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0]  IV3   = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] P3A   = 128'hd9313225f88406e5a55909c5aff5269a;
  localparam logic [127:0] C3A   = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] P3B   = 128'h86a7a9531534f7da2e4c303d8a318a72;
  localparam logic [127:0] C3B   = 128'he3aa212f2c02a4e035c17e2329aca12e;
  localparam logic [127:0] H3    = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] H256  = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] C256  = 128'hcea7403d4d606b6e074ec5d3baf39d18;
  localparam logic [127:0] C0_P5 = 128'h0388dace600000000000000000000000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start0, start1, key_reuse, keylen, last, blk_valid, res_ready, sel;
  logic [1:0]   mode;
  logic [95:0]  iv;
  logic [255:0] key;
  logic [127:0] blk;
  logic [4:0]   bytes;
  logic         rdy0, resv0, resl0, busy0, rdy1, resv1, resl1, busy1;
  logic [127:0] res0, res1;
  logic         rdy, resv, resl;
  logic [127:0] res;

  assign rdy  = sel ? rdy1 : rdy0;
  assign resv = sel ? resv1 : resv0;
  assign resl = sel ? resl1 : resl0;
  assign res  = sel ? res1 : res0;

  int n_cmp = 0;
  int n_bad = 0;
  int init_cnt = 0;
  int rdy_cnt = 0;

  gctr_stream dut (
    .iClk(clk), .iRst(rst), .iStart(start0), .iMode(mode), .iKeyReuse(key_reuse),
    .iIV(iv), .iKey(key), .iKeylen(keylen), .iBlock(blk), .iBlock_bytes(bytes),
    .iLast(last), .iBlock_valid(blk_valid), .oBlock_ready(rdy0), .oResult(res0),
    .oResult_valid(resv0), .iResult_ready(res_ready), .oResult_last(resl0), .oBusy(busy0)
  );

  gctr_stream #(.CTR_START(32'hFFFFFFFF)) dut_wrap (
    .iClk(clk), .iRst(rst), .iStart(start1), .iMode(mode), .iKeyReuse(key_reuse),
    .iIV(iv), .iKey(key), .iKeylen(keylen), .iBlock(blk), .iBlock_bytes(bytes),
    .iLast(last), .iBlock_valid(blk_valid), .oBlock_ready(rdy1), .oResult(res1),
    .oResult_valid(resv1), .iResult_ready(res_ready), .oResult_last(resl1), .oBusy(busy1)
  );

  always @(negedge clk) begin
    if (dut.aes_init) init_cnt++;
    if (rdy0) rdy_cnt++;
  end

  // driver tasks: each returns at a falling edge
  task automatic start_msg(input logic s, input logic [1:0] m, input logic reuse,
                           input logic [255:0] k, input logic kl, input logic [95:0] v);
    @(negedge clk);
    sel = s; mode = m; key_reuse = reuse; key = k; keylen = kl; iv = v;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b, input logic [4:0] nb, input logic l,
                            output logic ok);
    ok = 1'b0;
    blk = b; bytes = nb; last = l; blk_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resv) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic get_result(output logic [127:0] r, output logic l, output logic ok);
    wait_valid(ok);
    r = res; l = resl;
    if (ok) @(posedge clk);
    @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b0 || res0 !== '0 || resv0 !== 1'b0 || resl0 !== 1'b0 || busy0 !== 1'b0) begin
      $display("FAIL reset_outputs: rdy=%b res=%h v=%b last=%b busy=%b, required all 0",
               rdy0, res0, resv0, resl0, busy0);
      n_bad++;
    end
    n_cmp++;
    if (dut.state !== ST_IDLE || dut.ctr !== 32'd2) begin
      $display("FAIL reset_state: state=%0d ctr=%h, required IDLE ctr=2", dut.state, dut.ctr);
      n_bad++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hash_key();
    logic [127:0] r; logic l, ok; int c0;
    c0 = rdy_cnt;
    start_msg(1'b0, 2'd1, 1'b1, 256'h0, 1'b0, 96'h0);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || r !== H0 || l !== 1'b1) begin
      $display("FAIL hash_key: ok=%b res=%h last=%b, required %h last=1", ok, r, l, H0);
      n_bad++;
    end
    n_cmp++;
    if (rdy_cnt !== c0) begin
      $display("FAIL hash_no_block: ready cycles=%0d, required 0", rdy_cnt - c0);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (busy0 !== 1'b0) begin
      $display("FAIL hash_idle: busy=%b, required 0", busy0);
      n_bad++;
    end
  endtask

  task automatic test_pretag();
    logic [127:0] r; logic l, ok;
    start_msg(1'b0, 2'd2, 1'b1, 256'h0, 1'b0, 96'h0);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || r !== Y0_0 || l !== 1'b1) begin
      $display("FAIL pretag: ok=%b res=%h last=%b, required %h last=1", ok, r, l, Y0_0);
      n_bad++;
    end
  endtask

  task automatic test_ctr_single();
    logic [127:0] r; logic l, ok, ok_s;
    start_msg(1'b0, 2'd0, 1'b1, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd0, 1'b1, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C0 || l !== 1'b1) begin
      $display("FAIL ctr_single: ok=%b%b res=%h last=%b, required %h last=1", ok_s, ok, r, l, C0);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] r; logic l, ok, ok_s;
    start_msg(1'b0, 2'd3, 1'b0, {K3, 128'h0}, 1'b0, IV3);
    send_block(P3A, 5'd16, 1'b0, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C3A || l !== 1'b0) begin
      $display("FAIL b2b_first: ok=%b%b res=%h last=%b, required %h last=0", ok_s, ok, r, l, C3A);
      n_bad++;
    end
    send_block(P3B, 5'd16, 1'b1, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C3B || l !== 1'b1) begin
      $display("FAIL b2b_second: ok=%b%b res=%h last=%b, required %h last=1", ok_s, ok, r, l, C3B);
      n_bad++;
    end
    start_msg(1'b0, 2'd1, 1'b1, 256'h0, 1'b0, 96'h0);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || r !== H3) begin
      $display("FAIL b2b_hash: ok=%b res=%h, required %h", ok, r, H3);
      n_bad++;
    end
  endtask

  task automatic test_aes256();
    logic [127:0] r; logic l, ok, ok_s;
    start_msg(1'b0, 2'd1, 1'b0, 256'h0, 1'b1, 96'h0);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || r !== H256) begin
      $display("FAIL aes256_hash: ok=%b res=%h, required %h", ok, r, H256);
      n_bad++;
    end
    start_msg(1'b0, 2'd0, 1'b1, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd16, 1'b1, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C256) begin
      $display("FAIL aes256_ctr: ok=%b%b res=%h, required %h", ok_s, ok, r, C256);
      n_bad++;
    end
  endtask

  task automatic test_partial_stall();
    logic [127:0] r0; logic ok, ok_s, stable;
    res_ready = 1'b0;
    start_msg(1'b0, 2'd0, 1'b0, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd5, 1'b1, ok_s);
    wait_valid(ok);
    r0 = res0;
    n_cmp++;
    if (!ok_s || !ok || r0 !== C0_P5 || resl0 !== 1'b1) begin
      $display("FAIL partial_mask: ok=%b%b res=%h last=%b, required %h last=1",
               ok_s, ok, r0, resl0, C0_P5);
      n_bad++;
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res0 !== r0 || resv0 !== 1'b1 || resl0 !== 1'b1) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      $display("FAIL stall_stable: res=%h v=%b, required %h held valid", res0, resv0, r0);
      n_bad++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (resv0 !== 1'b0 || busy0 !== 1'b0) begin
      $display("FAIL stall_release: v=%b busy=%b, required 0 0", resv0, busy0);
      n_bad++;
    end
  endtask

  task automatic test_key_reuse();
    logic [127:0] r; logic l, ok, ok_s; int c0;
    c0 = init_cnt;
    start_msg(1'b0, 2'd0, 1'b1, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd20, 1'b1, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C0 || init_cnt !== c0) begin
      $display("FAIL key_reuse: ok=%b%b res=%h inits=%0d, required %h inits=0",
               ok_s, ok, r, init_cnt - c0, C0);
      n_bad++;
    end
  endtask

  task automatic test_ctr_wrap();
    logic [127:0] r; logic l, ok, ok_s; logic [31:0] m_ctr;
    m_ctr = 32'hFFFFFFFF;
    start_msg(1'b1, 2'd0, 1'b0, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd16, 1'b0, ok_s);
    n_cmp++;
    if (!ok_s || dut_wrap.aes_in !== {96'h0, m_ctr}) begin
      $display("FAIL wrap_ctr1: ok=%b block=%h, required %h", ok_s, dut_wrap.aes_in, {96'h0, m_ctr});
      n_bad++;
    end
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || l !== 1'b0) begin
      $display("FAIL wrap_first_last: ok=%b last=%b, required 0", ok, l);
      n_bad++;
    end
    m_ctr = m_ctr + 32'd1;
    send_block(128'h0, 5'd16, 1'b1, ok_s);
    n_cmp++;
    if (!ok_s || dut_wrap.aes_in !== {96'h0, m_ctr}) begin
      $display("FAIL wrap_ctr2: ok=%b block=%h, required %h", ok_s, dut_wrap.aes_in, {96'h0, m_ctr});
      n_bad++;
    end
    get_result(r, l, ok);
    n_cmp++;
    if (!ok || r !== H0 || l !== 1'b1) begin
      $display("FAIL wrap_result: ok=%b res=%h last=%b, required %h last=1", ok, r, l, H0);
      n_bad++;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ok_s, seen, stray;
    start_msg(1'b0, 2'd0, 1'b1, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd16, 1'b1, ok_s);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dut.state == ST_CIPHER) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (!ok_s || !seen || busy0 !== 1'b0 || resv0 !== 1'b0 || res0 !== '0 || rdy0 !== 1'b0 ||
        resl0 !== 1'b0 || dut.state !== ST_IDLE) begin
      $display("FAIL reset_mid: ok=%b cipher=%b busy=%b v=%b res=%h rdy=%b last=%b state=%0d, required idle zeros",
               ok_s, seen, busy0, resv0, res0, rdy0, resl0, dut.state);
      n_bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resv0 || busy0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      $display("FAIL reset_abandon: v=%b busy=%b, required no activity", resv0, busy0);
      n_bad++;
    end
  endtask

  task automatic test_post_reset();
    logic [127:0] r; logic l, ok, ok_s; int c0;
    c0 = init_cnt;
    start_msg(1'b0, 2'd0, 1'b1, 256'h0, 1'b0, 96'h0);
    send_block(128'h0, 5'd16, 1'b1, ok_s);
    get_result(r, l, ok);
    n_cmp++;
    if (!ok_s || !ok || r !== C0 || init_cnt !== c0 + 1) begin
      $display("FAIL post_reset_init: ok=%b%b res=%h inits=%0d, required %h inits=1",
               ok_s, ok, r, init_cnt - c0, C0);
      n_bad++;
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 2'd0; key_reuse = 1'b0;
    iv = '0; key = '0; keylen = 1'b0; blk = '0; bytes = 5'd16; last = 1'b0;
    blk_valid = 1'b0; res_ready = 1'b1; sel = 1'b0;
    test_reset();
    test_hash_key();
    test_pretag();
    test_ctr_single();
    test_back_to_back();
    test_aes256();
    test_partial_stall();
    test_key_reuse();
    test_ctr_wrap();
    test_reset_mid();
    test_post_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
